bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 106 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3, fixed latency).
// Define OVF_SATURATE_EN to show 9999 on overflow instead of EEEE.
module bin_to_bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  data1,
  output logic [3:0]  data2,
  output logic [3:0]  data3,
  output logic [3:0]  data4
);

`ifdef OVF_SATURATE_EN
  localparam logic [15:0] OVF_DIGITS = 16'h9999;
`else
  localparam logic [15:0] OVF_DIGITS = 16'hEEEE;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [13:0] sr_q;
  logic [15:0] bcd_q;
  logic [15:0] bcd_d;
  logic        ovfp_q;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;
  logic [15:0] dig_q;

  always_comb begin
    bcd_d = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Cycle 15 in SHIFT publishes the result; scratch never reaches the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
      ovfp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            sr_q    <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovfp_q  <= (bin > 14'd9999);
          end
        end
        SHIFT: begin
          if (cnt_q == 4'd14) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            ovf_q   <= ovfp_q;
            dig_q   <= ovfp_q ? OVF_DIGITS : bcd_q;
          end else begin
            {bcd_q, sr_q} <= {bcd_d[14:0], sr_q, 1'b0};
            cnt_q         <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign data1 = dig_q[15:12];
  assign data2 = dig_q[11:8];
  assign data3 = dig_q[7:4];
  assign data4 = dig_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected
// {ovf,digits} and done edge; a negedge monitor pops and compares.
module tb_bin_to_bcd_seq;

`ifdef OVF_SATURATE_EN
  localparam logic [15:0] OVF_EXP = 16'h9999;
`else
  localparam logic [15:0] OVF_EXP = 16'hEEEE;
`endif
  localparam int LIMIT = 100;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  data1;
  logic [3:0]  data2;
  logic [3:0]  data3;
  logic [3:0]  data4;

  bin_to_bcd_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .data1 (data1),
    .data2 (data2),
    .data3 (data3),
    .data4 (data4)
  );

  typedef struct {
    logic [16:0] v;
    int          e;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic prev_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [16:0] outs();
    return {ovf, data1, data2, data3, data4};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (prev_done) chk("busy_drop", 32'({busy, done}), 32'(0));
    prev_done = done;
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(1), 32'(0));
      end else begin
        e = q.pop_front();
        chk("digits", 32'(outs()), 32'(e.v));
        chk("latency", 32'(cyc), 32'(e.e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [13:0] v, input logic [16:0] exp);
    exp_t e;
    e.v = exp;
    e.e = cyc + 1 + 15;
    q.push_back(e);
    start = 1'b1;
    bin   = v;
    step();
    start = 1'b0;
    bin   = 14'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q.size() != 0) && n < LIMIT) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(n >= LIMIT), 32'(0));
    if (n >= LIMIT) q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 32'({busy, done, outs()}), 32'(0));
    rst_n = 1'b1;

    // first edge after release accepts
    issue(14'd1234, {1'b0, 16'h1234});
    wait_idle();

    issue(14'd0, {1'b0, 16'h0000});
    wait_idle();
    repeat (3) step();
    chk("hold_zero", 32'(outs()), 32'({1'b0, 16'h0000}));
    issue(14'd9999, {1'b0, 16'h9999});
    repeat (7) step();
    chk("mid_conv_hold", 32'({busy, outs()}), 32'({2'b10, 16'h0000}));
    wait_idle();

    issue(14'd12345, {1'b1, OVF_EXP});
    wait_idle();
    issue(14'd42, {1'b0, 16'h0042});
    wait_idle();

    // restarts during a conversion are dropped
    issue(14'd500, {1'b0, 16'h0500});
    repeat (4) step();
    start = 1'b1;
    bin   = 14'd9999;
    step();
    start = 1'b0;
    repeat (9) step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (3) step();
    chk("no_queued_start", 32'({busy, q.size() == 0}), 32'({1'b0, 1'b1}));
    wait_idle();

    // reset aborts 8765 mid-flight
    start = 1'b1;
    bin   = 14'd8765;
    step();
    start = 1'b0;
    repeat (7) step();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort_outputs", 32'({busy, done, outs()}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue(14'd8765, {1'b0, 16'h8765});
    wait_idle();

    // held start: conversions 17 edges apart
    begin
      int k;
      exp_t e;
      k = cyc + 1;
      for (int i = 0; i < 3; i++) begin
        e.v = {1'b0, 16'h0007};
        e.e = k + 15 + 17 * i;
        q.push_back(e);
      end
      start = 1'b1;
      bin   = 14'd7;
      while (cyc < k + 40) step();
      start = 1'b0;
    end
    wait_idle();

    repeat (3) step();
    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
